// File: rtl/inc_comp_pkg.sv
// Shared constants and types for the dual increment-and-compare datapath.
package inc_comp_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : inc_comp_pkg

// File: rtl/inc_comp_if.sv
// Enable inputs and max-count output of inc_comp, grouped as one bus.
interface inc_comp_if #(
  parameter int unsigned WIDTH = inc_comp_pkg::DEFAULT_WIDTH
);

  logic             INCA;
  logic             INCB;
  logic [WIDTH-1:0] C;

  modport master (
    output INCA,
    output INCB,
    input  C
  );

  modport slave (
    input  INCA,
    input  INCB,
    output C
  );

endinterface : inc_comp_if

// File: rtl/inc_comp_up_counter.sv
// Free-running modulo-2^WIDTH up-counter with synchronous reset and enable.
module up_counter #(
  parameter int unsigned WIDTH = inc_comp_pkg::DEFAULT_WIDTH
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Wraps naturally at 2^WIDTH; no carry out is kept.
  always_ff @(posedge ck) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule : up_counter

// File: rtl/inc_comp.sv
// Two independent up-counters feeding a registered unsigned max comparator.
module inc_comp
  import inc_comp_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic       ck,
  input  logic       rst,
  inc_comp_if.slave  bus
);

  logic [WIDTH-1:0] cnt_a_q;
  logic [WIDTH-1:0] cnt_b_q;

  up_counter #(.WIDTH(WIDTH)) cnt_a (
    .ck  (ck),
    .rst (rst),
    .en  (bus.INCA),
    .q   (cnt_a_q)
  );

  up_counter #(.WIDTH(WIDTH)) cnt_b (
    .ck  (ck),
    .rst (rst),
    .en  (bus.INCB),
    .q   (cnt_b_q)
  );

  // Uses pre-update counts, so C trails the counters by one edge; ties pick A.
  always_ff @(posedge ck) begin
    if (rst) begin
      bus.C <= '0;
    end else begin
      bus.C <= (cnt_a_q >= cnt_b_q) ? cnt_a_q : cnt_b_q;
    end
  end

endmodule : inc_comp

// File: tb/tb_inc_comp.sv
// Directed self-checking bench for inc_comp with hand-computed expectations.
module tb_inc_comp;
  import inc_comp_pkg::*;

  localparam int unsigned WIDTH = DEFAULT_WIDTH;

  logic ck;
  logic rst;
  int   n_vec;
  int   n_err;

  inc_comp_if #(.WIDTH(WIDTH)) bus ();

  inc_comp #(.WIDTH(WIDTH)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus.slave)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic drive(input logic r, input logic ia, input logic ib);
    rst      = r;
    bus.INCA = ia;
    bus.INCB = ib;
  endtask

  task automatic check_abc(input string tag, input int ea, input int eb, input int ec);
    check({tag, ".a"}, 32'(dut.cnt_a.q), 32'(ea));
    check({tag, ".b"}, 32'(dut.cnt_b.q), 32'(eb));
    check({tag, ".c"}, 32'(bus.C), 32'(ec));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset held with both enables high: everything stays zero.
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_abc("reset", 0, 0, 0);
    end

    // A only for 5 edges; C trails A by one edge.
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_abc("a_only", i, 0, i - 1);
    end

    // Both enabled for 4 edges.
    drive(1'b0, 1'b1, 1'b1);
    tick();
    check_abc("both_first", 6, 1, 5);
    for (int i = 2; i <= 4; i++) tick();
    check_abc("both_end", 9, 4, 8);

    // B only for 6 edges: C holds 9 until B passes it.
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_abc("b_only", 9, 4 + i, 9);
    end
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check_abc("b_wins", 9, 10, 10);

    // Wrap: reset, bring A=B=3, then A up to 255, then one more.
    drive(1'b1, 1'b0, 1'b0);
    tick();
    check_abc("wrap_rst", 0, 0, 0);
    drive(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    check_abc("tie", 4, 3, 3);
    for (int i = 0; i < 251; i++) tick();
    check_abc("a_max", 255, 3, 254);
    tick();
    check_abc("a_wrap", 0, 3, 255);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check_abc("c_drop", 0, 3, 3);

    // Mid-operation reset with A=7, B=2 and INCA high.
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) tick();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check_abc("pre_rst", 7, 2, 6);
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check_abc("mid_rst", 0, 0, 0);
    drive(1'b0, 1'b1, 1'b0);
    tick();
    check_abc("resume1", 1, 0, 0);
    tick();
    check_abc("resume2", 2, 0, 1);

    // Hold: nothing moves once C has caught up.
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check_abc("hold_settle", 2, 0, 2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_abc("hold", 2, 0, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_inc_comp
